viewfinder_frame_sequencer: RTL

//  Frame-level controller for the CCD readout datapath. It arbitrates between continuous

---
 rtl/viewfinder_frame_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/viewfinder_frame_sequencer.sv
// Frame-level controller for the CCD readout path: arbitrates preview and capture frames,
// arms the DMA per frame and verifies the preview word count.
module viewfinder_frame_sequencer #(
  parameter int          VF_X        = 240,
  parameter int          VF_Y        = 160,
  parameter int          EXP_WORDS   = VF_X * VF_Y / 2,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        preview_en_i,
  input  logic        capture_req_i,
  input  logic        abort_i,
  input  logic        frame_start_i,
  input  logic        frame_end_i,
  input  logic        word_pulse_i,
  output logic        skipper_en_o,
  output logic        capture_en_o,
  output logic        dma_start_o,
  output logic        frame_done_o,
  output logic        frame_err_o,
  output logic        mode_o,
  output logic [15:0] word_cnt_o,
  output logic        busy_o
);

  localparam logic [15:0] EXP_CNT      = 16'(EXP_WORDS);
  localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYC - 24'd1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    CHECK,
    ERR
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        mode;
  logic        capture_pending;
  logic [23:0] timeout;
  logic [15:0] cnt_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Abort outranks frame_end and the timeout; the CHECK-cycle word still counts.
  always_comb begin
    next_state = state;
    cnt_next   = word_cnt_o;
    if ((state == RUN || state == CHECK) && word_pulse_i && !mode && word_cnt_o != 16'hFFFF)
      cnt_next = word_cnt_o + 16'd1;
    case (state)
      IDLE:    if (capture_pending || preview_en_i) next_state = ARM;
      ARM:     if (abort_i) next_state = ERR;
               else if (frame_start_i) next_state = RUN;
      RUN:     if (abort_i) next_state = ERR;
               else if (frame_end_i) next_state = CHECK;
               else if (timeout == TIMEOUT_LAST) next_state = ERR;
      CHECK:   next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skipper_en_o    <= 1'b0;
      capture_en_o    <= 1'b0;
      dma_start_o     <= 1'b0;
      frame_done_o    <= 1'b0;
      frame_err_o     <= 1'b0;
      mode_o          <= 1'b0;
      word_cnt_o      <= 16'd0;
      busy_o          <= 1'b0;
      mode            <= 1'b0;
      capture_pending <= 1'b0;
      timeout         <= 24'd0;
    end else begin
      dma_start_o  <= 1'b0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      busy_o       <= (next_state != IDLE);

      if (capture_req_i)
        capture_pending <= 1'b1;
      else if (state == IDLE && next_state == ARM && capture_pending)
        capture_pending <= 1'b0;

      if (state == IDLE && next_state == ARM)
        mode <= capture_pending;

      case (state)
        ARM: begin
          if (next_state == RUN) begin
            dma_start_o  <= 1'b1;
            word_cnt_o   <= 16'd0;
            timeout      <= 24'd0;
            skipper_en_o <= ~mode;
            capture_en_o <= mode;
            mode_o       <= mode;
          end
        end
        RUN: begin
          word_cnt_o <= cnt_next;
          timeout    <= timeout + 24'd1;
        end
        CHECK: begin
          word_cnt_o   <= cnt_next;
          skipper_en_o <= 1'b0;
          capture_en_o <= 1'b0;
          frame_done_o <= 1'b1;
          frame_err_o  <= !mode && (cnt_next != EXP_CNT);
        end
        ERR: begin
          skipper_en_o <= 1'b0;
          capture_en_o <= 1'b0;
          frame_done_o <= 1'b1;
          frame_err_o  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
